// File: rtl/mag_sample_source.sv
// mag_sample_source: I/Q alpha-max-plus-beta-min magnitude, peak-hold decimation, paced amplitude/next output
// Ports: clk, rst_n (async active-low); in_valid/in_i/in_q signed sample stream, no backpressure;
//        clr_ovf clears sticky ovf; amplitude/next paced result strobe, at least NEXT_GAP cycles apart.
module mag_sample_source #(
    parameter int IN_W     = 16,
    parameter int DECIM    = 4,
    parameter int NEXT_GAP = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_i,
    input  logic [IN_W-1:0] in_q,
    input  logic            clr_ovf,
    output logic [15:0]     amplitude,
    output logic            next,
    output logic            ovf
);
    localparam int AW = IN_W - 1;
    localparam int MW = (IN_W + 1 > 17) ? IN_W + 1 : 17;

    logic [IN_W-1:0] w_neg_i, w_neg_q;
    logic [AW-1:0]   w_abs_i, w_abs_q;
    logic [MW-1:0]   w_sum;
    logic [15:0]     w_mag16, w_pval, w_head;
    logic [1:0]      w_widx;
    logic            w_push, w_fire, w_pop, w_drop, w_wr;

    logic            r_v1, r_v2, r_v3, r_next, r_ovf;
    logic [AW-1:0]   r_a, r_b, r_mx, r_mn;
    logic [15:0]     r_mag, r_peak, r_buf0, r_buf1, r_amp;
    logic [8:0]      r_dcnt;
    logic [1:0]      r_cnt;
    logic [7:0]      r_gap;

    // Negating the most negative code wraps back to itself (MSB still set), which flags saturation.
    assign w_neg_i = -in_i;
    assign w_neg_q = -in_q;
    assign w_abs_i = !in_i[IN_W-1] ? in_i[AW-1:0] : w_neg_i[IN_W-1] ? '1 : w_neg_i[AW-1:0];
    assign w_abs_q = !in_q[IN_W-1] ? in_q[AW-1:0] : w_neg_q[IN_W-1] ? '1 : w_neg_q[AW-1:0];

    assign w_sum   = MW'(r_mx) + MW'(r_mn >> 2) + MW'(r_mn >> 3);
    assign w_mag16 = |w_sum[MW-1:16] ? 16'hFFFF : w_sum[15:0];

    assign w_push = r_v3 && r_dcnt == 9'(DECIM - 1);
    assign w_pval = r_mag > r_peak ? r_mag : r_peak;

    // A fresh push may go straight out when the buffer is empty, giving the 4-cycle latency.
    assign w_fire = (r_cnt != 2'd0 || w_push) && r_gap == 8'd0 && !r_next;
    assign w_pop  = w_fire && r_cnt != 2'd0;
    assign w_drop = w_push && r_cnt == 2'd2 && !w_pop;
    assign w_wr   = w_push && !w_drop && !(w_fire && r_cnt == 2'd0);
    assign w_head = r_cnt != 2'd0 ? r_buf0 : w_pval;
    assign w_widx = r_cnt - {1'b0, w_pop};

    assign amplitude = r_amp;
    assign next      = r_next;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_mx  <= '0;
            r_mn  <= '0;
            r_mag <= '0;
        end else begin
            r_v1  <= in_valid;
            r_a   <= w_abs_i;
            r_b   <= w_abs_q;
            r_v2  <= r_v1;
            r_mx  <= r_a > r_b ? r_a : r_b;
            r_mn  <= r_a > r_b ? r_b : r_a;
            r_v3  <= r_v2;
            r_mag <= w_mag16;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_peak <= '0;
        end else if (r_v3) begin
            r_dcnt <= w_push ? 9'd0 : r_dcnt + 9'd1;
            r_peak <= w_push ? 16'd0 : w_pval;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_amp  <= '0;
            r_next <= 1'b0;
            r_gap  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + {1'b0, w_wr} - {1'b0, w_pop};
            if (w_pop)
                r_buf0 <= r_buf1;
            // Later assignment wins, so a write into slot 0 overrides the shift.
            if (w_wr && !w_widx[0])
                r_buf0 <= w_pval;
            if (w_wr && w_widx[0])
                r_buf1 <= w_pval;
            if (w_fire)
                r_amp <= w_head;
            r_next <= w_fire;
            r_gap  <= w_fire ? 8'(NEXT_GAP - 1) : r_gap != 8'd0 ? r_gap - 8'd1 : r_gap;
            r_ovf  <= w_drop ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
        end
    end
endmodule
